// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD conversion arbiter: FSM encoding and index sizing.
package bcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width of a requester index; never below one bit so N_REQ=1 style corners stay legal.
    function automatic int idx_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last_idx+1 upward, wrapping modulo N_REQ.
module rr_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    int   cand;
    logic found;

    // First requesting index after the previous winner wins; the previous winner itself comes last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_idx) + k) % N_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one bin2bcd core among N_REQ requesters with round-robin arbitration and a
// per-phase timeout so a stuck core cannot hang a requester forever.
//
// state | meaning
// IDLE  | waiting for any req; arbitrates and latches the winner's operand
// START | conv_init held high until the core drops conv_ready
// CONV  | waiting for the core to raise conv_ready, then capture the result
// DONE  | one-cycle done pulse to the winner with the captured result
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    done,
    output logic [31:0]         rsp_dn,
    output logic [31:0]         rsp_up,
    output logic                rsp_err,
    output logic                busy,
    output logic [31:0]         conv_bin,
    output logic                conv_init,
    input  logic                conv_ready,
    input  logic [31:0]         conv_dn,
    input  logic [31:0]         conv_up
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [31:0]        sel_data;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_hit;
    logic               load_grant;
    logic               clr_cnt;
    logic               cnt_en;
    logic               cap_rsp;
    logic               cap_to;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req),
        .last_idx  (last_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_data = req_data[32*int'(grant_idx) +: 32];
    assign cnt_hit  = (cnt == CNT_MAX);

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode plus datapath strobes and the state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        clr_cnt    = 1'b0;
        cnt_en     = 1'b0;
        cap_rsp    = 1'b0;
        cap_to     = 1'b0;
        conv_init  = 1'b0;
        busy       = 1'b1;
        done       = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    load_grant = 1'b1;
                    clr_cnt    = 1'b1;
                    state_nxt  = ST_START;
                end
            end
            ST_START: begin
                conv_init = 1'b1;
                if (!conv_ready) begin
                    clr_cnt   = 1'b1;
                    state_nxt = ST_CONV;
                end else if (cnt_hit) begin
                    cap_to    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_CONV: begin
                if (conv_ready) begin
                    cap_rsp   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt_hit) begin
                    cap_to    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                done      = N_REQ'(1) << win_idx;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Winner operand and index are latched at grant and held until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_bin <= '0;
            win_idx  <= '0;
            last_idx <= LAST_RST;
        end else if (load_grant) begin
            conv_bin <= sel_data;
            win_idx  <= grant_idx;
            last_idx <= grant_idx;
        end
    end

    // Phase cycle counter, cleared on entry to START and to CONV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (clr_cnt) cnt <= '0;
        else if (cnt_en)  cnt <= cnt + CNT_W'(1);
    end

    // Response registers keep their last value until the next capture or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_dn  <= '0;
            rsp_up  <= '0;
            rsp_err <= 1'b0;
        end else if (cap_rsp) begin
            rsp_dn  <= conv_dn;
            rsp_up  <= conv_up;
            rsp_err <= 1'b0;
        end else if (cap_to) begin
            rsp_dn  <= '0;
            rsp_up  <= '0;
            rsp_err <= 1'b1;
        end
    end

endmodule
